// File: rtl/anode_scan_ctrl.sv
// ============================================================================
// anode_scan_ctrl
// Eight-digit seven-segment scan controller with per-slot anode blanking.
// Revision: 1.0
// ============================================================================
`default_nettype none

module anode_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic       aclk,
  input  logic       reset,
  input  logic       enable,
  input  logic [0:7] digit_mask,
  output logic [0:2] digit_select,
  output logic [0:7] anode,
  output logic       frame_start
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam state_t          SLOT_START = (BLANK == 0) ? S_DRIVE : S_BLANK;
  localparam logic [CW-1:0]   DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  state_t        state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [2:0]    digit, nxt_digit;
  logic [0:7]    nxt_anode;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_digit = digit;
    if (!enable) begin
      nxt_state = S_IDLE;
      nxt_cnt   = '0;
      nxt_digit = 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          nxt_state = SLOT_START;
          nxt_cnt   = '0;
          nxt_digit = 3'd0;
        end
        S_BLANK: begin
          nxt_cnt = cnt + 1'b1;
          if (cnt == BLANK_LAST) nxt_state = S_DRIVE;
        end
        S_DRIVE: begin
          if (cnt == DIV_LAST) begin
            // 3-bit index wraps 7 -> 0 naturally, so frames stay exactly 8 slots.
            nxt_cnt   = '0;
            nxt_digit = digit + 3'd1;
            nxt_state = SLOT_START;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
          nxt_digit = 3'd0;
        end
      endcase
    end
  end

  // Only the selected digit can ever go low, so at most one anode is active.
  always_comb begin
    nxt_anode = '1;
    if (nxt_state == S_DRIVE) begin
      for (int i = 0; i < 8; i++) begin
        if (nxt_digit == 3'(i)) nxt_anode[i] = ~digit_mask[i];
      end
    end
  end

  // Outputs are computed from the next state so they change on the same edge.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      digit        <= 3'd0;
      digit_select <= 3'b000;
      anode        <= 8'b1111_1111;
      frame_start  <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      digit        <= nxt_digit;
      digit_select <= nxt_digit;
      anode        <= nxt_anode;
      frame_start  <= (nxt_state != S_IDLE) && (nxt_digit == 3'd0) && (nxt_cnt == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_anode_scan_ctrl.sv
// ============================================================================
// tb_anode_scan_ctrl
// Randomized self-checking bench against a frame-time reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_anode_scan_ctrl;

  localparam int DIV   = 8;
  localparam int FRAME = 8 * DIV;

  logic       aclk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [0:7] digit_mask = 8'hFF;

  logic [0:2] ds_a, ds_b;
  logic [0:7] an_a, an_b;
  logic       fs_a, fs_b;

  always #5 aclk = ~aclk;

  anode_scan_ctrl #(.DIV(DIV), .BLANK(2)) dut_a (
    .aclk(aclk), .reset(reset), .enable(enable), .digit_mask(digit_mask),
    .digit_select(ds_a), .anode(an_a), .frame_start(fs_a)
  );

  anode_scan_ctrl #(.DIV(DIV), .BLANK(0)) dut_b (
    .aclk(aclk), .reset(reset), .enable(enable), .digit_mask(digit_mask),
    .digit_select(ds_b), .anode(an_b), .frame_start(fs_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: position t within the frame (cycles since the digit-0 slot began).
  bit         active = 1'b0;
  int         t = 0;
  logic [0:7] mask_q = 8'hFF;

  always @(posedge aclk) begin
    if (reset || !enable) begin
      active = 1'b0;
      t      = 0;
    end else if (!active) begin
      active = 1'b1;
      t      = 0;
    end else begin
      t = (t + 1) % FRAME;
    end
    mask_q = digit_mask;
  end

  function automatic logic [0:7] exp_anode(input int blank);
    logic [0:7] a;
    int d;
    a = 8'hFF;
    d = t / DIV;
    if (active && (t % DIV) >= blank) a[d] = ~mask_q[d];
    return a;
  endfunction

  task automatic compare_all();
    logic [31:0] exp_ds;
    logic [31:0] exp_fs;
    exp_ds = active ? 32'(t / DIV) : 32'd0;
    exp_fs = (active && t == 0) ? 32'd1 : 32'd0;
    check("sel_b2",   32'(ds_a), exp_ds);
    check("anode_b2", 32'(an_a), 32'(exp_anode(2)));
    check("frame_b2", 32'(fs_a), exp_fs);
    check("sel_b0",   32'(ds_b), exp_ds);
    check("anode_b0", 32'(an_b), 32'(exp_anode(0)));
    check("frame_b0", 32'(fs_b), exp_fs);
    check("onelow_b2", 32'($countones(~an_a) <= 1), 32'd1);
    check("onelow_b0", 32'($countones(~an_b) <= 1), 32'd1);
  endtask

  task automatic step(input bit r, input bit en, input logic [0:7] m);
    @(negedge aclk);
    compare_all();
    reset      = r;
    enable     = en;
    digit_mask = m;
  endtask

  task automatic run_until(input int target, input logic [0:7] m);
    int guard;
    guard = 0;
    while (!(active && t == target) && guard < 2 * FRAME) begin
      step(1'b0, 1'b1, m);
      guard++;
    end
    check("reach_pos", 32'(active && t == target), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge aclk);
    step(1'b1, 1'b0, 8'hFF);
    // Start-up and three full frames with every digit lit.
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 3 * FRAME + 1; i++) step(1'b0, 1'b1, 8'hFF);
    // Alternate digits masked.
    for (int i = 0; i < FRAME + 2; i++) step(1'b0, 1'b1, 8'b1010_1010);
    // Enable drop in digit 3 drive phase, then restart.
    run_until(3 * DIV + 4, 8'hFF);
    step(1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < DIV + 2; i++) step(1'b0, 1'b1, 8'hFF);
    // One-cycle reset in digit 5 drive phase with enable held.
    run_until(5 * DIV + 3, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < DIV + 2; i++) step(1'b0, 1'b1, 8'hFF);
    // Randomized traffic: mask changes mid-slot, enable drops, reset pulses.
    begin
      logic [0:7] m;
      bit en;
      bit r;
      m  = 8'hFF;
      en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 9) == 0) m = 8'($urandom);
        if ($urandom_range(0, 49) == 0) en = ~en;
        else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
        r = ($urandom_range(0, 99) == 0);
        step(r, en, m);
      end
    end
    step(1'b0, 1'b1, 8'hFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
